de_morgan_sweep: RTL and testbench

- Self-checking, parametrised De Morgan verifier for the lab logic library.
- On start, it walks every combination of two W-bit operands.
- For each vector it evaluates both sides of law 1, ~(a|b) == ~a&~b, and/or law 2, ~(a&b) == ~a|~b, with registered compare.
- Reports the mismatch count and the first failing vector, with a start/busy/done handshake and a fault-injection hook so mismatch detection itself is testable.

---
 rtl/de_morgan_pkg.sv | 16 +
 rtl/de_morgan_nbit.sv | 18 +
 rtl/de_morgan_sweep.sv | 132 +++++++++++++
 tb/tb_de_morgan_sweep.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/de_morgan_pkg.sv
// Shared types and constants for the De Morgan exhaustive sweep checker.
package de_morgan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_LAW1 = 2'b01;
    localparam logic [1:0] MODE_LAW2 = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/de_morgan_nbit.sv
// Both sides of both De Morgan laws for one pair of W-bit operands.
module de_morgan_nbit #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] law1_lhs,
    output logic [W-1:0] law1_rhs,
    output logic [W-1:0] law2_lhs,
    output logic [W-1:0] law2_rhs
);

    assign law1_lhs = ~(a | b);
    assign law1_rhs = ~a & ~b;
    assign law2_lhs = ~(a & b);
    assign law2_rhs = ~a | ~b;

endmodule

// File: rtl/de_morgan_sweep.sv
// Exhaustive De Morgan verifier: walks all operand pairs, compares both law sides
// one cycle later, and keeps the mismatch count and first failing vector.
//
// state | meaning
// IDLE  | results held, waiting for start
// RUN   | applying vector cnt, counter advancing
// FLUSH | evaluating the last registered vector
// DONE  | one-cycle done pulse
module de_morgan_sweep
    import de_morgan_pkg::*;
#(
    parameter int W  = 2,
    parameter int CW = 2*W+1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          fault_inj,
    output logic [W-1:0]  a_out,
    output logic [W-1:0]  b_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] mismatch_cnt,
    output logic          fail_seen,
    output logic [W-1:0]  first_fail_a,
    output logic [W-1:0]  first_fail_b
);

    localparam logic [2*W-1:0] CNT_LAST = '1;

    state_t         state, state_nxt;
    logic [2*W-1:0] cnt;
    logic [1:0]     mode_q;
    logic [W-1:0]   a_cur, b_cur;
    logic [W-1:0]   l1_lhs, l1_rhs, l2_lhs, l2_rhs;

    logic           s1_vld, s1_fault;
    logic [W-1:0]   s1_a, s1_b;
    logic [W-1:0]   s1_l1_lhs, s1_l1_rhs, s1_l2_lhs, s1_l2_rhs;

    logic [W-1:0]   fault_mask;
    logic           law1_fail, law2_fail, mismatch, start_sweep;

    assign a_cur = cnt[2*W-1:W];
    assign b_cur = cnt[W-1:0];

    de_morgan_nbit #(.W(W)) u_nbit (
        .a        (a_cur),
        .b        (b_cur),
        .law1_lhs (l1_lhs),
        .law1_rhs (l1_rhs),
        .law2_lhs (l2_lhs),
        .law2_rhs (l2_rhs)
    );

    // Fault flips only rhs bit 0, enough to force a mismatch for either law.
    assign fault_mask  = W'(s1_fault);
    assign law1_fail   = s1_l1_lhs != (s1_l1_rhs ^ fault_mask);
    assign law2_fail   = s1_l2_lhs != (s1_l2_rhs ^ fault_mask);
    assign mismatch    = s1_vld &&
                         (((mode_q == MODE_LAW1 || mode_q == MODE_BOTH) && law1_fail) ||
                          ((mode_q == MODE_LAW2 || mode_q == MODE_BOTH) && law2_fail));
    assign start_sweep = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mode_q       <= MODE_NONE;
            s1_vld       <= 1'b0;
            s1_fault     <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_l1_lhs    <= '0;
            s1_l1_rhs    <= '0;
            s1_l2_lhs    <= '0;
            s1_l2_rhs    <= '0;
            mismatch_cnt <= '0;
            fail_seen    <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
        end else begin
            state     <= state_nxt;
            s1_vld    <= (state == RUN);
            s1_fault  <= fault_inj && (state == RUN);
            s1_a      <= a_cur;
            s1_b      <= b_cur;
            s1_l1_lhs <= l1_lhs;
            s1_l1_rhs <= l1_rhs;
            s1_l2_lhs <= l2_lhs;
            s1_l2_rhs <= l2_rhs;

            if (state == RUN)
                cnt <= cnt + 1'b1;
            else if (start_sweep)
                cnt <= '0;

            if (start_sweep) begin
                mode_q       <= mode;
                mismatch_cnt <= '0;
                fail_seen    <= 1'b0;
                first_fail_a <= '0;
                first_fail_b <= '0;
            end else if (mismatch) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
                if (!fail_seen) begin
                    fail_seen    <= 1'b1;
                    first_fail_a <= s1_a;
                    first_fail_b <= s1_b;
                end
            end
        end
    end

    assign a_out = (state == RUN) ? a_cur : '0;
    assign b_out = (state == RUN) ? b_cur : '0;
    assign busy  = (state == RUN) || (state == FLUSH);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_de_morgan_sweep.sv
// Directed bench for de_morgan_sweep at W=2: clean, faulted, masked, disturbed and aborted sweeps.
module tb_de_morgan_sweep;

    localparam int W  = 2;
    localparam int CW = 2*W+1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          fault_inj = 1'b0;
    logic [W-1:0]  a_out, b_out;
    logic          busy, done;
    logic [CW-1:0] mismatch_cnt;
    logic          fail_seen;
    logic [W-1:0]  first_fail_a, first_fail_b;

    int checks = 0;
    int errors = 0;

    de_morgan_sweep #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .fault_inj    (fault_inj),
        .a_out        (a_out),
        .b_out        (b_out),
        .busy         (busy),
        .done         (done),
        .mismatch_cnt (mismatch_cnt),
        .fail_seen    (fail_seen),
        .first_fail_a (first_fail_a),
        .first_fail_b (first_fail_b)
    );

    always #5 clk = ~clk;

    // fmode: 0 = no fault, 1 = fault every cycle, 2 = fault only on vector 9.
    // disturb: pulse start and switch mode to 00 while vector 6 is applied.
    task automatic do_sweep(input logic [1:0] m, input int fmode, input bit disturb,
                            output int busy_n, output int done_n, output bit seq_ok);
        bit finished = 0;
        logic [1:0] ea, eb;
        @(negedge clk);
        start = 1'b1;
        mode = m;
        fault_inj = (fmode == 1);
        @(negedge clk);
        start = 1'b0;
        busy_n = 0;
        done_n = 0;
        seq_ok = 1;
        for (int t = 0; t < 60; t++) begin
            if (done) done_n++;
            if (busy) begin
                if (busy_n < 16) begin
                    ea = 2'(busy_n / 4);
                    eb = 2'(busy_n % 4);
                end else begin
                    ea = 2'd0;
                    eb = 2'd0;
                end
                if (a_out !== ea || b_out !== eb) seq_ok = 0;
                fault_inj = (fmode == 1) || (fmode == 2 && busy_n == 9);
                start = disturb && busy_n == 6;
                if (disturb && busy_n == 6) mode = 2'b00;
                busy_n++;
            end else begin
                start = 1'b0;
                if (busy_n > 0 && done_n > 0) begin
                    finished = 1;
                    break;
                end
            end
            @(negedge clk);
        end
        fault_inj = 1'b0;
        start = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL sweep_timeout: busy_cycles=%0d done_pulses=%0d, required sweep to finish", busy_n, done_n);
        end
    endtask

    task automatic check_common(input string name, input int busy_n, input int done_n, input bit seq_ok);
        checks++;
        if (busy_n !== 17) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d want 17", name, busy_n);
        end
        checks++;
        if (done_n !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d want 1", name, done_n);
        end
        checks++;
        if (!seq_ok) begin
            errors++;
            $display("FAIL %s_vector_sequence: got out-of-order a_out/b_out want 0/0..3/3 then 0/0", name);
        end
    endtask

    task automatic check_results(input string name, input logic [CW-1:0] ecnt, input logic efail,
                                 input logic [W-1:0] ea, input logic [W-1:0] eb);
        checks++;
        if (mismatch_cnt !== ecnt) begin
            errors++;
            $display("FAIL %s_mismatch_cnt: got %0d want %0d", name, mismatch_cnt, ecnt);
        end
        checks++;
        if (fail_seen !== efail) begin
            errors++;
            $display("FAIL %s_fail_seen: got %0b want %0b", name, fail_seen, efail);
        end
        checks++;
        if (first_fail_a !== ea || first_fail_b !== eb) begin
            errors++;
            $display("FAIL %s_first_fail: got a=%0d b=%0d want a=%0d b=%0d", name,
                     first_fail_a, first_fail_b, ea, eb);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || a_out !== 2'd0 || b_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%0b done=%0b a=%0d b=%0d want all 0", busy, done, a_out, b_out);
        end
        check_results("reset", 5'd0, 1'b0, 2'd0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%0b done=%0b want 0 0", busy, done);
        end
    endtask

    task automatic test_law1_clean;
        int bn, dn;
        bit sq;
        do_sweep(2'b01, 0, 0, bn, dn, sq);
        check_common("law1", bn, dn, sq);
        check_results("law1", 5'd0, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic test_both_fault_all;
        int bn, dn;
        bit sq;
        do_sweep(2'b11, 1, 0, bn, dn, sq);
        check_common("both_fault", bn, dn, sq);
        check_results("both_fault", 5'd16, 1'b1, 2'd0, 2'd0);
        repeat (4) @(negedge clk);
        checks++;
        if (mismatch_cnt !== 5'd16 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_in_idle: got cnt=%0d done=%0b want 16 0", mismatch_cnt, done);
        end
    endtask

    task automatic test_law2_single;
        int bn, dn;
        bit sq;
        do_sweep(2'b10, 2, 0, bn, dn, sq);
        check_common("law2_single", bn, dn, sq);
        check_results("law2_single", 5'd1, 1'b1, 2'd2, 2'd1);
    endtask

    task automatic test_mode_none;
        int bn, dn;
        bit sq;
        do_sweep(2'b00, 1, 0, bn, dn, sq);
        check_common("none", bn, dn, sq);
        check_results("none", 5'd0, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic test_mid_sweep_ignore;
        int bn, dn;
        bit sq;
        do_sweep(2'b01, 0, 1, bn, dn, sq);
        check_common("mid_ignore", bn, dn, sq);
        check_results("mid_ignore", 5'd0, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic test_reset_abort;
        bit reached = 0;
        int late_done = 0;
        int bn, dn;
        bit sq;
        @(negedge clk);
        start = 1'b1;
        mode = 2'b11;
        fault_inj = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (busy && a_out == 2'd1 && b_out == 2'd1) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL abort_reach_cnt5: got timeout want a_out=1 b_out=1");
        end
        checks++;
        if (mismatch_cnt !== 5'd4) begin
            errors++;
            $display("FAIL abort_partial_cnt: got %0d want 4", mismatch_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || a_out !== 2'd0 || mismatch_cnt !== 5'd0) begin
            errors++;
            $display("FAIL abort_async: got busy=%0b done=%0b a=%0d cnt=%0d want all 0",
                     busy, done, a_out, mismatch_cnt);
        end
        fault_inj = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        checks++;
        if (late_done !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", late_done);
        end
        do_sweep(2'b11, 1, 0, bn, dn, sq);
        check_common("after_abort", bn, dn, sq);
        check_results("after_abort", 5'd16, 1'b1, 2'd0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_law1_clean();
        test_both_fault_all();
        test_law2_single();
        test_mode_none();
        test_mid_sweep_ignore();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
